// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: load-use hazard detection,
// EX flush handling, illegal-opcode bubbling and saturating debug counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [6:0]       ID_opcode,
  input  logic [2:0]       ID_funct3,
  input  logic             ID_funct7b5,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic [XLEN-1:0]  ID_rs1_data,
  input  logic [XLEN-1:0]  ID_rs2_data,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [XLEN-1:0]  ID_PC,
  input  logic             ID_cntl_MemWrite,
  input  logic             ID_cntl_MemRead,
  input  logic             ID_cntl_RegWrite,
  input  logic             ID_cntl_Branch,
  input  logic [2:0]       ID_sel_MemToReg,
  input  logic [1:0]       ID_sel_ALUSrc,
  input  logic [1:0]       ID_sel_jump,
  input  logic [3:0]       ID_ALUOp,
  input  logic             EX_flush,
  output logic             EX_valid,
  output logic             EX_illegal,
  output logic [2:0]       EX_funct3,
  output logic             EX_funct7b5,
  output logic [4:0]       EX_rs1,
  output logic [4:0]       EX_rs2,
  output logic [4:0]       EX_rd,
  output logic [XLEN-1:0]  EX_rs1_data,
  output logic [XLEN-1:0]  EX_rs2_data,
  output logic [XLEN-1:0]  EX_imm,
  output logic [XLEN-1:0]  EX_PC,
  output logic             EX_cntl_MemWrite,
  output logic             EX_cntl_MemRead,
  output logic             EX_cntl_RegWrite,
  output logic             EX_cntl_Branch,
  output logic [2:0]       EX_sel_MemToReg,
  output logic [1:0]       EX_sel_ALUSrc,
  output logic [1:0]       EX_sel_jump,
  output logic [3:0]       EX_ALUOp,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       legal;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       load_use;
  logic       take_next;
  logic       illegal_next;
  logic [1:0] cnt_inc;

  always_comb begin
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (ID_opcode)
      7'b0000011: begin legal = 1'b1; uses_rs1 = 1'b1; end
      7'b0010011: begin legal = 1'b1; uses_rs1 = 1'b1; end
      7'b0010111: begin legal = 1'b1; end
      7'b0100011: begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0110011: begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0110111: begin legal = 1'b1; end
      7'b1100011: begin legal = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100111: begin legal = 1'b1; uses_rs1 = 1'b1; end
      7'b1101111: begin legal = 1'b1; end
      default: ;
    endcase
  end

  assign load_use = EX_valid & EX_cntl_MemRead & (EX_rd != 5'd0) & ID_valid &
                    ((uses_rs1 & (ID_rs1 == EX_rd)) | (uses_rs2 & (ID_rs2 == EX_rd)));
  assign hazard_stall = load_use & ~EX_flush;

  // Only a legal, unflushed, unstalled instruction may carry decoder controls;
  // every other case selects constants so X selects never propagate.
  assign take_next    = ID_valid &  legal & ~EX_flush & ~load_use;
  assign illegal_next = ID_valid & ~legal & ~EX_flush & ~load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_valid         <= 1'b0;
      EX_illegal       <= 1'b0;
      EX_funct3        <= '0;
      EX_funct7b5      <= 1'b0;
      EX_rs1           <= '0;
      EX_rs2           <= '0;
      EX_rd            <= '0;
      EX_rs1_data      <= '0;
      EX_rs2_data      <= '0;
      EX_imm           <= '0;
      EX_PC            <= '0;
      EX_cntl_MemWrite <= 1'b0;
      EX_cntl_MemRead  <= 1'b0;
      EX_cntl_RegWrite <= 1'b0;
      EX_cntl_Branch   <= 1'b0;
      EX_sel_MemToReg  <= '0;
      EX_sel_ALUSrc    <= '0;
      EX_sel_jump      <= '0;
      EX_ALUOp         <= '0;
    end else begin
      EX_valid         <= take_next;
      EX_illegal       <= illegal_next;
      EX_funct3        <= ID_funct3;
      EX_funct7b5      <= ID_funct7b5;
      EX_rs1           <= ID_rs1;
      EX_rs2           <= ID_rs2;
      EX_rs1_data      <= ID_rs1_data;
      EX_rs2_data      <= ID_rs2_data;
      EX_imm           <= ID_imm;
      EX_PC            <= ID_PC;
      EX_rd            <= take_next ? ID_rd            : 5'd0;
      EX_cntl_MemWrite <= take_next ? ID_cntl_MemWrite : 1'b0;
      EX_cntl_MemRead  <= take_next ? ID_cntl_MemRead  : 1'b0;
      EX_cntl_RegWrite <= take_next ? ID_cntl_RegWrite : 1'b0;
      EX_cntl_Branch   <= take_next ? ID_cntl_Branch   : 1'b0;
      EX_sel_MemToReg  <= take_next ? ID_sel_MemToReg  : 3'd0;
      EX_sel_ALUSrc    <= take_next ? ID_sel_ALUSrc    : 2'd0;
      EX_sel_jump      <= take_next ? ID_sel_jump      : 2'd0;
      EX_ALUOp         <= take_next ? ID_ALUOp         : 4'd0;
    end
  end

  // Index 0 counts load-use bubbles, index 1 counts flushes.
  assign cnt_inc = {EX_flush, hazard_stall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_reg <= '0;
      else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bubble_cnt = g_cnt[0].cnt_reg;
  assign flush_cnt  = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a stage-contents model checked every cycle
// against a default instance and a narrow-counter instance.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ID_valid = 1'b0;
  logic [6:0] ID_opcode = '0;
  logic [2:0] ID_funct3 = '0;
  logic ID_funct7b5 = 1'b0;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, ID_rd = '0;
  logic [XLEN-1:0] ID_rs1_data = '0, ID_rs2_data = '0, ID_imm = '0, ID_PC = '0;
  logic ID_cntl_MemWrite = 1'b0, ID_cntl_MemRead = 1'b0, ID_cntl_RegWrite = 1'b0, ID_cntl_Branch = 1'b0;
  logic [2:0] ID_sel_MemToReg = '0;
  logic [1:0] ID_sel_ALUSrc = '0, ID_sel_jump = '0;
  logic [3:0] ID_ALUOp = '0;
  logic EX_flush = 1'b0;

  logic EX_valid, EX_illegal, EX_funct7b5;
  logic [2:0] EX_funct3;
  logic [4:0] EX_rs1, EX_rs2, EX_rd;
  logic [XLEN-1:0] EX_rs1_data, EX_rs2_data, EX_imm, EX_PC;
  logic EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite, EX_cntl_Branch;
  logic [2:0] EX_sel_MemToReg;
  logic [1:0] EX_sel_ALUSrc, EX_sel_jump;
  logic [3:0] EX_ALUOp;
  logic hazard_stall;
  logic [15:0] bubble_cnt, flush_cnt;

  logic s_valid, s_illegal, s_funct7b5;
  logic [2:0] s_funct3;
  logic [4:0] s_rs1, s_rs2, s_rd;
  logic [XLEN-1:0] s_rs1_data, s_rs2_data, s_imm, s_PC;
  logic s_mw, s_mr, s_rw, s_br;
  logic [2:0] s_m2r;
  logic [1:0] s_alusrc, s_jump;
  logic [3:0] s_aluop;
  logic s_hazard;
  logic [3:0] s_bubble_cnt, s_flush_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
    .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd(ID_rd), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_PC(ID_PC), .ID_cntl_MemWrite(ID_cntl_MemWrite), .ID_cntl_MemRead(ID_cntl_MemRead),
    .ID_cntl_RegWrite(ID_cntl_RegWrite), .ID_cntl_Branch(ID_cntl_Branch),
    .ID_sel_MemToReg(ID_sel_MemToReg), .ID_sel_ALUSrc(ID_sel_ALUSrc), .ID_sel_jump(ID_sel_jump),
    .ID_ALUOp(ID_ALUOp), .EX_flush(EX_flush), .EX_valid(EX_valid), .EX_illegal(EX_illegal),
    .EX_funct3(EX_funct3), .EX_funct7b5(EX_funct7b5), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2),
    .EX_rd(EX_rd), .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data), .EX_imm(EX_imm),
    .EX_PC(EX_PC), .EX_cntl_MemWrite(EX_cntl_MemWrite), .EX_cntl_MemRead(EX_cntl_MemRead),
    .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_Branch(EX_cntl_Branch),
    .EX_sel_MemToReg(EX_sel_MemToReg), .EX_sel_ALUSrc(EX_sel_ALUSrc), .EX_sel_jump(EX_sel_jump),
    .EX_ALUOp(EX_ALUOp), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .CNT_W(4)) sat_dut (
    .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_opcode(ID_opcode),
    .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd(ID_rd), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_PC(ID_PC), .ID_cntl_MemWrite(ID_cntl_MemWrite), .ID_cntl_MemRead(ID_cntl_MemRead),
    .ID_cntl_RegWrite(ID_cntl_RegWrite), .ID_cntl_Branch(ID_cntl_Branch),
    .ID_sel_MemToReg(ID_sel_MemToReg), .ID_sel_ALUSrc(ID_sel_ALUSrc), .ID_sel_jump(ID_sel_jump),
    .ID_ALUOp(ID_ALUOp), .EX_flush(EX_flush), .EX_valid(s_valid), .EX_illegal(s_illegal),
    .EX_funct3(s_funct3), .EX_funct7b5(s_funct7b5), .EX_rs1(s_rs1), .EX_rs2(s_rs2),
    .EX_rd(s_rd), .EX_rs1_data(s_rs1_data), .EX_rs2_data(s_rs2_data), .EX_imm(s_imm),
    .EX_PC(s_PC), .EX_cntl_MemWrite(s_mw), .EX_cntl_MemRead(s_mr),
    .EX_cntl_RegWrite(s_rw), .EX_cntl_Branch(s_br),
    .EX_sel_MemToReg(s_m2r), .EX_sel_ALUSrc(s_alusrc), .EX_sel_jump(s_jump),
    .EX_ALUOp(s_aluop), .hazard_stall(s_hazard), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic valid, illegal, mw, mr, rw, br, f7;
    logic [2:0] m2r, f3;
    logic [1:0] alusrc, jump;
    logic [3:0] aluop;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } ex_t;

  ex_t m;
  int  n_bub, n_fl;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                      7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111};
  endfunction

  // A load in EX whose destination the instruction in ID actually reads.
  function automatic bit model_load_use();
    bit reads1, reads2;
    reads1 = ID_opcode inside {7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b1100111};
    reads2 = ID_opcode inside {7'b0100011, 7'b0110011, 7'b1100011};
    if (!(m.valid && m.mr && m.rd != 0 && ID_valid)) return 1'b0;
    return (reads1 && ID_rs1 == m.rd) || (reads2 && ID_rs2 == m.rd);
  endfunction

  function automatic ex_t model_next();
    ex_t n;
    n = '{default: 0};
    n.f3 = ID_funct3;  n.f7 = ID_funct7b5;  n.rs1 = ID_rs1;  n.rs2 = ID_rs2;
    n.d1 = ID_rs1_data; n.d2 = ID_rs2_data; n.imm = ID_imm; n.pc = ID_PC;
    if (EX_flush || model_load_use()) begin
    end else if (ID_valid && !is_legal(ID_opcode)) begin
      n.illegal = 1'b1;
    end else if (ID_valid) begin
      n.valid = 1'b1; n.mw = ID_cntl_MemWrite; n.mr = ID_cntl_MemRead;
      n.rw = ID_cntl_RegWrite; n.br = ID_cntl_Branch; n.m2r = ID_sel_MemToReg;
      n.alusrc = ID_sel_ALUSrc; n.jump = ID_sel_jump; n.aluop = ID_ALUOp; n.rd = ID_rd;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= '{default: 0};
      n_bub <= 0;
      n_fl  <= 0;
    end else begin
      m     <= model_next();
      n_fl  <= n_fl + (EX_flush ? 1 : 0);
      n_bub <= n_bub + ((!EX_flush && model_load_use()) ? 1 : 0);
    end
  end

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 64'(EX_valid), 64'(m.valid));
      chk("illegal", 64'(EX_illegal), 64'(m.illegal));
      chk("ctl", 64'({EX_cntl_MemWrite, EX_cntl_MemRead, EX_cntl_RegWrite, EX_cntl_Branch}),
                 64'({m.mw, m.mr, m.rw, m.br}));
      chk("sel", 64'({EX_sel_MemToReg, EX_sel_ALUSrc, EX_sel_jump, EX_ALUOp}),
                 64'({m.m2r, m.alusrc, m.jump, m.aluop}));
      chk("regs", 64'({EX_rs1, EX_rs2, EX_rd, EX_funct3, EX_funct7b5}),
                  64'({m.rs1, m.rs2, m.rd, m.f3, m.f7}));
      chk("data12", {EX_rs1_data, EX_rs2_data}, {m.d1, m.d2});
      chk("imm_pc", {EX_imm, EX_PC}, {m.imm, m.pc});
      chk("hazard", 64'(hazard_stall), 64'(model_load_use() && !EX_flush));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(sat(n_bub, 16)));
      chk("flush_cnt", 64'(flush_cnt), 64'(sat(n_fl, 16)));
      chk("sat_bubble_cnt", 64'(s_bubble_cnt), 64'(sat(n_bub, 4)));
      chk("sat_flush_cnt", 64'(s_flush_cnt), 64'(sat(n_fl, 4)));
      chk("no_x", 64'($isunknown({EX_valid, EX_illegal, EX_cntl_MemWrite, EX_cntl_MemRead,
          EX_cntl_RegWrite, EX_cntl_Branch, EX_sel_MemToReg, EX_sel_ALUSrc, EX_sel_jump,
          EX_ALUOp, EX_rd, hazard_stall, bubble_cnt, flush_cnt})), 64'(0));
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [6:0] OP_LW = 7'b0000011, OP_ALUI = 7'b0010011, OP_R = 7'b0110011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [3:0] ctl, input logic [2:0] m2r, input logic [1:0] asrc,
                         input logic [1:0] jmp, input logic [3:0] aluop, input logic [31:0] pc);
    ID_valid = v; ID_opcode = op; ID_funct3 = f3; ID_funct7b5 = pc[2];
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd;
    {ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch} = ctl;
    ID_sel_MemToReg = m2r; ID_sel_ALUSrc = asrc; ID_sel_jump = jmp; ID_ALUOp = aluop;
    ID_PC = pc; ID_rs1_data = pc + 32'h1000; ID_rs2_data = pc + 32'h2000; ID_imm = pc + 32'h3;
  endtask

  task automatic lw_x7(input logic [31:0] pc);
    present(1, OP_LW, 3'b010, 5'd2, 5'd0, 5'd7, 4'b0110, 3'b001, 2'b01, 2'b00, 4'b0000, pc);
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_valid", 64'(EX_valid), 64'(0));
    chk("reset_cnt", 64'({bubble_cnt, flush_cnt}), 64'(0));

    // pass-through ADD x5
    present(1, OP_R, 3'b000, 5'd1, 5'd2, 5'd5, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h100);
    tick();
    chk("add_rd", 64'(EX_rd), 64'(5));
    chk("add_aluop", 64'(EX_ALUOp), 64'(4'b0100));
    chk("add_rw_valid", 64'({EX_cntl_RegWrite, EX_valid}), 64'(2'b11));

    // LW x7 ; ADD x8,x7,x1
    lw_x7(32'h104);
    tick();
    present(1, OP_R, 3'b000, 5'd7, 5'd1, 5'd8, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h108);
    #1 chk("lu_stall", 64'(hazard_stall), 64'(1));
    tick();
    chk("lu_bubble", 64'({EX_valid, EX_cntl_RegWrite}), 64'(0));
    chk("lu_bubble_cnt", 64'(bubble_cnt), 64'(1));
    chk("lu_stall_drop", 64'(hazard_stall), 64'(0));
    tick();
    chk("lu_proceed", 64'({EX_valid, EX_rd}), 64'({1'b1, 5'd8}));

    // LW x7 ; ADDI x8,x0,3 with rs2 field = 7
    lw_x7(32'h10c);
    tick();
    present(1, OP_ALUI, 3'b000, 5'd0, 5'd7, 5'd8, 4'b0010, 3'b000, 2'b01, 2'b00, 4'b0000, 32'h110);
    #1 chk("addi_no_stall", 64'(hazard_stall), 64'(0));
    tick();
    chk("addi_pass", 64'({EX_valid, EX_rd}), 64'({1'b1, 5'd8}));

    // LW x0 ; ADD x1,x0,x0
    present(1, OP_LW, 3'b010, 5'd2, 5'd0, 5'd0, 4'b0110, 3'b001, 2'b01, 2'b00, 4'b0000, 32'h114);
    tick();
    present(1, OP_R, 3'b000, 5'd0, 5'd0, 5'd1, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h118);
    #1 chk("x0_no_stall", 64'(hazard_stall), 64'(0));
    tick();

    // flush together with load-use
    lw_x7(32'h11c);
    tick();
    present(1, OP_R, 3'b000, 5'd7, 5'd1, 5'd8, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h120);
    EX_flush = 1'b1;
    #1 chk("flush_no_stall", 64'(hazard_stall), 64'(0));
    tick();
    EX_flush = 1'b0;
    chk("flush_bubble", 64'(EX_valid), 64'(0));
    chk("flush_cnts", 64'({bubble_cnt, flush_cnt}), 64'({16'd1, 16'd1}));

    // a few other legal classes
    present(1, OP_SW, 3'b010, 5'd3, 5'd4, 5'd9, 4'b1000, 3'b000, 2'b01, 2'b00, 4'b0000, 32'h124);
    tick();
    present(1, OP_BR, 3'b001, 5'd3, 5'd4, 5'd0, 4'b0001, 3'b000, 2'b00, 2'b00, 4'b0001, 32'h128);
    tick();
    present(1, OP_JAL, 3'b000, 5'd0, 5'd0, 5'd1, 4'b0010, 3'b010, 2'b00, 2'b01, 4'b0000, 32'h12c);
    tick();
    chk("jal_jump", 64'({EX_sel_jump, EX_sel_MemToReg, EX_rd}), 64'({2'b01, 3'b010, 5'd1}));

    // illegal opcode with unknown decoder selects
    present(1, 7'b1111111, 3'b000, 5'd1, 5'd2, 5'd3, 4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, 32'h200);
    {ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch} = 'x;
    ID_sel_MemToReg = 'x; ID_sel_ALUSrc = 'x; ID_sel_jump = 'x; ID_ALUOp = 'x; ID_rd = 'x;
    tick();
    chk("ill_flag", 64'({EX_illegal, EX_valid}), 64'(2'b10));
    chk("ill_pc", 64'(EX_PC), 64'(32'h200));
    chk("ill_ctl_zero", 64'({EX_cntl_RegWrite, EX_sel_jump, EX_ALUOp, EX_rd}), 64'(0));
    present(0, OP_R, 3'b000, 5'd1, 5'd2, 5'd3, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h204);
    tick();
    chk("idle_bubble", 64'({EX_illegal, EX_valid}), 64'(0));

    // reset asserted mid-stall
    lw_x7(32'h208);
    tick();
    present(1, OP_R, 3'b000, 5'd7, 5'd1, 5'd8, 4'b0010, 3'b000, 2'b00, 2'b00, 4'b0100, 32'h20c);
    #1 chk("pre_rst_stall", 64'({hazard_stall, EX_valid}), 64'(2'b11));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ex", 64'({EX_valid, EX_cntl_MemRead, EX_rd, EX_PC}), 64'(0));
    chk("rst_async_stall", 64'(hazard_stall), 64'(0));
    chk("rst_async_cnt", 64'({bubble_cnt, flush_cnt}), 64'(0));
    tick();
    lw_x7(32'h300);
    ID_rs1 = 5'd7;
    rst_n = 1'b1;

    // saturation: self-dependent load gives a bubble every second edge
    repeat (40) tick();
    chk("sat_main_bub", 64'(bubble_cnt), 64'(20));
    chk("sat_small_bub", 64'(s_bubble_cnt), 64'(4'hF));
    EX_flush = 1'b1;
    repeat (20) tick();
    EX_flush = 1'b0;
    chk("sat_main_fl", 64'(flush_cnt), 64'(20));
    chk("sat_small_fl", 64'(s_flush_cnt), 64'(4'hF));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RV32I core. It registers the decoded control bundle and operands from ID into EX and detects load-use hazards, inserting one bubble and holding IF/ID. It applies branch/jump flushes from EX and replaces illegal opcodes with a bubble plus a registered illegal flag. It keeps saturating bubble and flush counters for debug.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- CNT_W, 16, width of perf counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- ID_valid  in  1  ID holds a real instruction
- ID_opcode  in  7  instruction[6:0]
- ID_funct3  in  3  instruction[14:12]
- ID_funct7b5  in  1  instruction[30]
- ID_rs1, ID_rs2, ID_rd  in  5 each  register indices
- ID_rs1_data, ID_rs2_data, ID_imm, ID_PC  in  XLEN each  operands
- ID_cntl_MemWrite, ID_cntl_MemRead, ID_cntl_RegWrite, ID_cntl_Branch  in  1 each  decoder controls
- ID_sel_MemToReg  in  3;  ID_sel_ALUSrc  in  2;  ID_sel_jump  in  2;  ID_ALUOp  in  4  decoder selects
- EX_flush  in  1  taken branch/jump resolved in EX this cycle
- EX_* outputs  out  same widths  registered copies of every ID_* input above except ID_valid/ID_opcode; plus EX_valid out 1, EX_illegal out 1
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Legal opcodes: 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111.
- uses_rs1: opcode in {0000011, 0010011, 0100011, 0110011, 1100011, 1100111}. uses_rs2: opcode in {0100011, 0110011, 1100011}.
- load_use = EX_valid & EX_cntl_MemRead & (EX_rd != 0) & ID_valid & ((uses_rs1 & ID_rs1 == EX_rd) | (uses_rs2 & ID_rs2 == EX_rd)).
- hazard_stall = load_use & ~EX_flush.
- Per-edge priority, highest first:
  1. EX_flush: EX becomes a bubble; flush_cnt++.
  2. load_use: EX becomes a bubble; bubble_cnt++. ID is held upstream, so the same instruction is re-presented next cycle.
  3. ID_valid & illegal opcode: EX becomes a bubble with EX_illegal=1 and EX_PC=ID_PC.
  4. ID_valid & legal opcode: all EX_* ← ID_*, EX_valid=1, EX_illegal=0.
  5. ~ID_valid: EX becomes a bubble.
- Bubble: EX_valid=0, EX_cntl_MemWrite/MemRead/RegWrite/Branch=0, EX_sel_jump=00, EX_ALUOp=0000, EX_sel_MemToReg=000, EX_sel_ALUSrc=00, EX_rd=0, EX_illegal=0 (except case 3).
  - Data fields (rs*_data, imm, PC, rs1, rs2, funct) still load from ID. This is don't-care, but must not be X after reset.
- X sanitising: decoder selects are X for illegal opcodes. No X may reach any EX_* output in bubble cases; only registered constants are used there.
- Counters saturate at all-ones. No wrap.

## Timing
- Reset (async assert, sync release): all EX_* outputs 0, EX_valid=0, EX_illegal=0, counters 0.
- hazard_stall is 0 while in reset because EX_valid=0.
- Latency: 1 cycle, ID on edge n → EX after edge n.
- hazard_stall is purely combinational from the current EX regs and ID inputs. It has no registered delay and is asserted for exactly one cycle per load-use pair.
  - On the next cycle EX holds a bubble, so load_use is 0 and the held instruction proceeds.
- EX_flush together with load_use: flush wins, hazard_stall=0, flush_cnt increments, bubble_cnt unchanged.
- Reset asserted mid-stall: outputs clear immediately, without waiting for a clock edge.

## Test plan
- Reset: rst_n=0 mid-cycle with EX_valid=1 → all outputs 0 before the next edge; hazard_stall=0.
- Pass-through: ADD (0110011, rd=5) with ID_valid=1 → next cycle EX_rd=5, EX_ALUOp=0100, EX_cntl_RegWrite=1, EX_valid=1.
- Load-use:
  - LW x7 then ADD x8,x7,x1 → hazard_stall=1 for one cycle, EX bubble (RegWrite=0), bubble_cnt=1.
  - The ADD then enters EX on the following edge.
  - Repeat with ADDI x8,x0,3 consuming ID_rs2 field=7 → no stall, since rs2 is unused.
- Load to x0: LW x0 then ADD x1,x0,x0 → hazard_stall=0.
- Flush priority: EX_flush=1 together with a load-use condition → hazard_stall=0, EX bubble, flush_cnt=1, bubble_cnt unchanged.
- Illegal/saturation:
  - Opcode 1111111 with X decoder selects → EX_illegal=1, EX_valid=0, no X on any output.
  - Force 65536 load-use bubbles → bubble_cnt holds 0xFFFF.
